// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the EX stage and the multiply/divide sequencer.
interface muldiv_if #(parameter int DATA_WIDTH = 32);

  logic                  start_i;
  logic [2:0]            op_i;
  logic [DATA_WIDTH-1:0] a_i;
  logic [DATA_WIDTH-1:0] b_i;
  logic                  flush_i;
  logic                  ready_o;
  logic                  stall_o;
  logic                  done_o;
  logic [DATA_WIDTH-1:0] result_o;

  modport master (
    output start_i, op_i, a_i, b_i, flush_i,
    input  ready_o, stall_o, done_o, result_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i, flush_i,
    output ready_o, stall_o, done_o, result_o
  );

endinterface

// File: rtl/muldiv_iter.sv
// Shift/add multiply and restoring divide datapath: one shared adder, one
// double-width register, and the final sign fix on the last iteration.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  step,
  input  logic                  is_div,
  input  logic                  sel_hi,
  input  logic                  neg,
  input  logic [DATA_WIDTH-1:0] mag_a,
  input  logic [DATA_WIDTH-1:0] mag_b,
  output logic [DATA_WIDTH-1:0] res
);

  localparam int W = DATA_WIDTH;
  localparam logic [2*W-1:0] ONE2W = {{(2*W-1){1'b0}}, 1'b1};

  logic [2*W-1:0] prod, prod_nxt, fix_src, fix;
  logic [W-1:0]   opnd;
  logic [W:0]     add_x, add_y, sum;
  logic           add_cin;
  logic           is_div_q, sel_hi_q, neg_q;

  // Multiply: {acc, multiplier} shifts right. Divide: {rem, dividend} shifts left.
  always_comb begin
    if (is_div_q) begin
      add_x   = prod[2*W-1:W-1];
      add_y   = ~{1'b0, opnd};
      add_cin = 1'b1;
    end else begin
      add_x   = {1'b0, prod[2*W-1:W]};
      add_y   = prod[0] ? {1'b0, opnd} : '0;
      add_cin = 1'b0;
    end
    sum = add_x + add_y + {{W{1'b0}}, add_cin};

    if (is_div_q)
      prod_nxt = sum[W] ? {prod[2*W-2:0], 1'b0} : {sum[W-1:0], prod[W-2:0], 1'b1};
    else
      prod_nxt = {sum, prod[W-1:1]};

    // Divide negates only the selected word, so it is zero-extended first.
    fix_src = is_div_q ? {{W{1'b0}}, (sel_hi_q ? prod_nxt[2*W-1:W] : prod_nxt[W-1:0])}
                       : prod_nxt;
    fix     = neg_q ? (~fix_src + ONE2W) : fix_src;
    res     = (sel_hi_q && !is_div_q) ? fix[2*W-1:W] : fix[W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod     <= '0;
      opnd     <= '0;
      is_div_q <= 1'b0;
      sel_hi_q <= 1'b0;
      neg_q    <= 1'b0;
    end else if (load) begin
      prod     <= {{W{1'b0}}, (is_div ? mag_a : mag_b)};
      opnd     <= is_div ? mag_b : mag_a;
      is_div_q <= is_div;
      sel_hi_q <= sel_hi;
      neg_q    <= neg;
    end else if (step) begin
      prod <= prod_nxt;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// RV32M multiply/divide sequencer: FSM, iteration counter, handshake, fast paths.
// Build option MULDIV_FAST_MUL_EN: single-cycle combinational multiply.
//   state | meaning
//   IDLE  | waiting for a request
//   BUSY  | one shift/add or shift/subtract iteration per cycle
//   DONE  | result valid, done_o high; may accept the next request
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  localparam int W = DATA_WIDTH;
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  muldiv_state_e        state, state_nxt;
  muldiv_op_e           op;
  logic [CNT_WIDTH-1:0] cnt;
  logic [W-1:0]         result_q, mag_a, mag_b, fast_res, iter_res;
  logic                 accept, last, fast, is_div, sel_hi, neg;
  logic                 sgn_a, sgn_b, neg_a, neg_b;

  assign op     = muldiv_op_e'(bus.op_i);
  assign accept = (state != BUSY) && bus.start_i && !bus.flush_i;
  assign last   = (cnt == CNT_WIDTH'(W-1));

`ifdef MULDIV_FAST_MUL_EN
  logic signed [W:0]     fm_a, fm_b;
  logic signed [2*W-1:0] fm_p;
  assign fm_a = {sgn_a & bus.a_i[W-1], bus.a_i};
  assign fm_b = {sgn_b & bus.b_i[W-1], bus.b_i};
  assign fm_p = (2*W)'(fm_a) * (2*W)'(fm_b);
`endif

  always_comb begin
    is_div = bus.op_i[2];
    sgn_a  = 1'b0;
    sgn_b  = 1'b0;
    sel_hi = 1'b1;
    case (op)
      OP_MUL:    begin sgn_a = 1'b1; sgn_b = 1'b1; sel_hi = 1'b0; end
      OP_MULH:   begin sgn_a = 1'b1; sgn_b = 1'b1; end
      OP_MULHSU: sgn_a = 1'b1;
      OP_DIV:    begin sgn_a = 1'b1; sgn_b = 1'b1; sel_hi = 1'b0; end
      OP_DIVU:   sel_hi = 1'b0;
      OP_REM:    begin sgn_a = 1'b1; sgn_b = 1'b1; end
      default:   ;
    endcase
    neg_a = sgn_a & bus.a_i[W-1];
    neg_b = sgn_b & bus.b_i[W-1];
    mag_a = neg_a ? -bus.a_i : bus.a_i;
    mag_b = neg_b ? -bus.b_i : bus.b_i;
    // Remainder follows the dividend; everything else follows the sign product.
    neg   = (is_div && sel_hi) ? neg_a : (neg_a ^ neg_b);

    fast     = 1'b0;
    fast_res = '0;
    if (is_div && bus.b_i == '0) begin
      fast     = 1'b1;
      fast_res = sel_hi ? bus.a_i : '1;
    end else if (is_div && sgn_a && bus.a_i == MIN_NEG && bus.b_i == '1) begin
      fast     = 1'b1;
      fast_res = sel_hi ? '0 : MIN_NEG;
    end
`ifdef MULDIV_FAST_MUL_EN
    else if (!is_div) begin
      fast     = 1'b1;
      fast_res = sel_hi ? fm_p[2*W-1:W] : fm_p[W-1:0];
    end
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = accept ? (fast ? DONE : BUSY) : IDLE;
      BUSY: begin
        if (bus.flush_i)
          state_nxt = IDLE;
        else if (last)
          state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      result_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt <= '0;
        if (fast)
          result_q <= fast_res;
      end else if (state == BUSY && !bus.flush_i) begin
        cnt <= last ? '0 : cnt + CNT_WIDTH'(1);
        if (last)
          result_q <= iter_res;
      end
    end
  end

  muldiv_iter #(.DATA_WIDTH(W)) u_iter (
    .clk    (clk),
    .reset  (reset),
    .load   (accept && !fast),
    .step   (state == BUSY && !bus.flush_i),
    .is_div (is_div),
    .sel_hi (sel_hi),
    .neg    (neg),
    .mag_a  (mag_a),
    .mag_b  (mag_b),
    .res    (iter_res)
  );

  assign bus.ready_o  = (state != BUSY);
  assign bus.done_o   = (state == DONE);
  assign bus.stall_o  = ((state != BUSY) && bus.start_i && !bus.flush_i) || (state == BUSY);
  assign bus.result_o = result_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed vector bench for muldiv_ctrl plus flush, back-to-back and reset sequences.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_if bus ();
  muldiv_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  vec_t        vecs[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] last_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] res, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res; v.lat = lat;
    return v;
  endfunction

  // Called at a negedge: present a request and confirm the stall is raised at once.
  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string name);
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.a_i     = a;
    bus.b_i     = b;
    #1;
    chk({name, " stall at accept"}, 32'(bus.stall_o), 32'd1);
  endtask

  // Counts negedges after the accept until done_o; stall must stay high until then.
  task automatic wait_done(output int lat, output logic stall_ok);
    lat = 0;
    stall_ok = 1'b1;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      bus.start_i = 1'b0;
      #1;
      if (bus.done_o) break;
      if (!bus.stall_o) stall_ok = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    logic stall_ok;
    logic saw_done;

    vecs.push_back(mk(OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT));
    vecs.push_back(mk(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT));
    vecs.push_back(mk(OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT));
    vecs.push_back(mk(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT));
    vecs.push_back(mk(OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT));
    vecs.push_back(mk(OP_MULH,   32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, MUL_LAT));
    vecs.push_back(mk(OP_MUL,    32'h8000_0000, 32'h0000_0003, 32'h8000_0000, MUL_LAT));
    vecs.push_back(mk(OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, DIV_LAT));
    vecs.push_back(mk(OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, DIV_LAT));
    vecs.push_back(mk(OP_DIVU,   32'd100,       32'd7,         32'd14,        DIV_LAT));
    vecs.push_back(mk(OP_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT));
    vecs.push_back(mk(OP_REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         DIV_LAT));
    vecs.push_back(mk(OP_DIV,    32'd0,         32'd5,         32'd0,         DIV_LAT));
    vecs.push_back(mk(OP_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         DIV_LAT));
    vecs.push_back(mk(OP_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1));
    vecs.push_back(mk(OP_REMU,   32'd5,         32'd0,         32'd5,         1));
    vecs.push_back(mk(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1));
    vecs.push_back(mk(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1));
    vecs.push_back(mk(OP_REMU,   32'd100,       32'd7,         32'd2,         DIV_LAT));

    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.op_i    = 3'b000;
    bus.a_i     = '0;
    bus.b_i     = '0;
    reset       = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset done", 32'(bus.done_o), 32'd0);
    chk("reset result", bus.result_o, 32'd0);
    chk("reset ready", 32'(bus.ready_o), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("idle stall", 32'(bus.stall_o), 32'd0);

    foreach (vecs[i]) begin
      @(negedge clk);
      launch(vecs[i].op, vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
      wait_done(lat, stall_ok);
      chk($sformatf("vec%0d result", i), bus.result_o, vecs[i].res);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d stall while busy", i), 32'(stall_ok), 32'd1);
      chk($sformatf("vec%0d stall low in done", i), 32'(bus.stall_o), 32'd0);
      last_exp = vecs[i].res;
    end

    // Flush during BUSY at T+10: back to IDLE at T+11 with no done and result held.
    @(negedge clk);
    launch(OP_DIV, 32'd100, 32'd7, "flush op");
    saw_done = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      bus.start_i = 1'b0;
      if (k == 10) bus.flush_i = 1'b1;
      #1;
      if (bus.done_o) saw_done = 1'b1;
    end
    @(negedge clk);
    bus.flush_i = 1'b0;
    #1;
    chk("flush idle ready", 32'(bus.ready_o), 32'd1);
    chk("flush no done", 32'(saw_done | bus.done_o), 32'd0);
    chk("flush result held", bus.result_o, last_exp);
    launch(OP_DIVU, 32'd100, 32'd7, "post-flush");
    wait_done(lat, stall_ok);
    chk("post-flush result", bus.result_o, 32'd14);
    chk("post-flush latency", 32'(lat), 32'(DIV_LAT));

    // Flush together with start while in DONE: done still pulses, request ignored.
    @(negedge clk);
    launch(OP_DIVU, 32'd5, 32'd0, "done-flush");
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.flush_i = 1'b1;
    #1;
    chk("done-flush done pulse", 32'(bus.done_o), 32'd1);
    chk("done-flush stall masked", 32'(bus.stall_o), 32'd0);
    chk("done-flush result", bus.result_o, 32'hFFFF_FFFF);
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    #1;
    chk("done-flush ignored done", 32'(bus.done_o), 32'd0);
    chk("done-flush idle ready", 32'(bus.ready_o), 32'd1);

    // Back-to-back accept from DONE, then reset in the middle of the second op.
    @(negedge clk);
    launch(OP_MUL, 32'd7, 32'hFFFF_FFFD, "b2b first");
    wait_done(lat, stall_ok);
    chk("b2b first result", bus.result_o, 32'hFFFF_FFEB);
    chk("b2b first latency", 32'(lat), 32'(MUL_LAT));
    launch(OP_DIVU, 32'd100, 32'd7, "b2b second");
    chk("b2b done during accept", 32'(bus.done_o), 32'd1);
    @(negedge clk);
    bus.start_i = 1'b0;
    #1;
    chk("b2b no bubble busy", 32'(bus.ready_o), 32'd0);
    chk("b2b done dropped", 32'(bus.done_o), 32'd0);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid-op reset done", 32'(bus.done_o), 32'd0);
    chk("mid-op reset result", bus.result_o, 32'd0);
    chk("mid-op reset ready", 32'(bus.ready_o), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    saw_done = 1'b0;
    repeat (35) begin
      @(negedge clk);
      #1;
      if (bus.done_o) saw_done = 1'b1;
    end
    chk("after reset no done", 32'(saw_done), 32'd0);

    @(negedge clk);
    launch(OP_REM, 32'hFFFF_FFF9, 32'd2, "recovery");
    wait_done(lat, stall_ok);
    chk("recovery result", bus.result_o, 32'hFFFF_FFFF);
    chk("recovery latency", 32'(lat), 32'(DIV_LAT));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Iterative RV32M multiply/divide sequencer beside the EX-stage ALU.
- Accepts one M-extension op at a time and runs a radix-2 shift/add (multiply) or restoring shift/subtract (divide) loop over DATA_WIDTH cycles.
- Raises a stall to the hazard unit while busy and returns one 32-bit result with a done pulse.
- Shares the pipeline's EX-stage operand muxes; writeback selects result_o when done_o is high.

Parameters:
DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH
CNT_WIDTH, 6, iteration counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH

Ports:
clk  input  1  clock; all state on rising edge
reset  input  1  asynchronous active-low reset (0 = reset asserted)
start_i  input  1  request; accepted only when ready_o=1
op_i  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
a_i  input  DATA_WIDTH  rs1 operand, sampled on accept
b_i  input  DATA_WIDTH  rs2 operand, sampled on accept
flush_i  input  1  abort in-flight op (branch mispredict/trap)
ready_o  output  1  high in IDLE and DONE
stall_o  output  1  combinational: (IDLE or DONE) & start_i & ~flush_i, or state==BUSY
done_o  output  1  one-cycle pulse, high exactly while in DONE
result_o  output  DATA_WIDTH  result; valid while done_o=1; holds until the next DONE

Behaviour:
- Reset: state=IDLE, done_o=0, result_o=0, counter=0, internal registers=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE/DONE -> BUSY: on start_i & ~flush_i. This is the accept cycle T. a_i, b_i and op_i are latched and converted to magnitudes; result signs are recorded.
- BUSY: one iteration per cycle, counter counts 0..DATA_WIDTH-1.
- BUSY -> DONE: after the iteration with counter==DATA_WIDTH-1. done_o is high at cycle T+DATA_WIDTH+1, so latency is 33 cycles for the default width.
- DONE -> IDLE: when there is no accept; DONE -> BUSY on a new accept, so back-to-back ops have no bubble.
- Fast paths, taken at accept and reaching DONE at T+1 with no BUSY cycles:
  - divide by zero: DIV/DIVU quotient = all ones; REM/REMU = a_i.
  - signed overflow (a_i=0x8000_0000, b_i=0xFFFF_FFFF): DIV = 0x8000_0000; REM = 0.
- Arithmetic:
  - Multiply uses a 2*DATA_WIDTH product register.
  - MUL returns the low word; MULH, MULHSU and MULHU return the high word.
  - Signed operands are multiplied as magnitudes; the 64-bit product is negated at the end if the signs differ.
  - DIV/DIVU truncate toward zero. REM takes the sign of the dividend.
  - The final sign correction is applied in the BUSY->DONE transition cycle.
- Flush:
  - flush_i in BUSY -> IDLE next cycle; done_o is not asserted and result_o is unchanged.
  - flush_i together with start_i -> request ignored.
  - flush_i in DONE -> done_o still pulses (the writeback squash is handled elsewhere) and the FSM goes to IDLE.
- start_i while in BUSY is ignored; the requester must hold it until accepted.
- Reset asserted mid-operation returns immediately to reset values; no done_o is produced.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined: multiply ops use a single combinational 33x33 signed multiplier and go IDLE -> DONE at T+1, bypassing BUSY. Divide ops are unchanged.
- Undefined: all multiplies are iterative with the full DATA_WIDTH+1 latency. No multiplier is inferred.

Decomposition:
- Package muldiv_pkg contains:
  - typedef enum muldiv_op_e (funct3 encodings above)
  - typedef enum muldiv_state_e {IDLE, BUSY, DONE}
  - constant MULDIV_FUNCT7 = 7'b0000001 for the decoder
- Sub-module muldiv_iter holds the shift/add-subtract datapath: product/remainder register, one DATA_WIDTH+1 adder, and final negation.
- muldiv_ctrl keeps the FSM, counter, handshake and fast-path detection.

Test Plan:
- MUL a=7, b=-3 (0xFFFF_FFFD) -> done_o at T+33, result=0xFFFF_FFEB; stall_o high T..T+32, low at T+33.
- MULHU a=0xFFFF_FFFF, b=0xFFFF_FFFF -> result=0xFFFF_FFFE. MULH same operands -> 0x0000_0000. MULHSU a=-1, b=0xFFFF_FFFF -> 0xFFFF_FFFF.
- DIV a=-7, b=2 -> result=0xFFFF_FFFD (-3); REM same operands -> 0xFFFF_FFFF (-1); DIVU a=100, b=7 -> 14.
- DIVU a=5, b=0 -> done_o at T+1, result=0xFFFF_FFFF; REM a=0x8000_0000, b=-1 -> done at T+1, result=0.
- DIV started, flush_i at T+10 -> state IDLE at T+11, no done_o, result_o keeps previous value; a new start at T+11 is accepted.
- Back-to-back: second start_i asserted in DONE cycle -> accepted with no bubble; reset pulled low at T+5 of the second op -> done_o=0 and result_o=0 immediately.
